rs_lane_dispatcher: RTL and testbench

Parametrised multi-lane stream bridge between the hardcloud requestor and NUM_LANES Reed-Solomon decoder cores. It cuts the incoming symbol stream into codeword blocks and assigns them round-robin to the lanes. Lane outputs are buffered in per-lane FIFOs and re-emitted in original block order. It adds a ready/valid handshake on both host-side ports and credit-based flow control toward lanes that have no backpressure.

---
 rtl/rs_lane_dispatcher_if.sv | 37 +++
 rtl/rs_lane_dispatcher.sv | 175 +++++++++++++++++
 tb/tb_rs_lane_dispatcher.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_lane_dispatcher_if.sv
// Host- and lane-side signal bundle for rs_lane_dispatcher.
// slave is the dispatcher's view; master is the surrounding host/lane environment.
interface rs_lane_dispatcher_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_LANES  = 4
);
    logic                            flush;

    logic [DATA_WIDTH-1:0]           in_data;
    logic                            in_valid;
    logic                            in_ready;

    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_valid;
    logic                            out_ready;

    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_out;
    logic [NUM_LANES-1:0]            lane_valid_out;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_in;
    logic [NUM_LANES-1:0]            lane_valid_in;

    logic [31:0]                     blocks_in;
    logic [31:0]                     blocks_out;
    logic                            overflow_err;

    modport slave (
        input  flush, in_data, in_valid, out_ready, lane_data_in, lane_valid_in,
        output in_ready, out_data, out_valid, lane_data_out, lane_valid_out,
               blocks_in, blocks_out, overflow_err
    );

    modport master (
        output flush, in_data, in_valid, out_ready, lane_data_in, lane_valid_in,
        input  in_ready, out_data, out_valid, lane_data_out, lane_valid_out,
               blocks_in, blocks_out, overflow_err
    );
endinterface

// File: rtl/rs_lane_dispatcher.sv
// Round-robin codeword dispatcher over NUM_LANES decoder lanes with per-lane
// reorder FIFOs and credit flow control so lanes never need backpressure.
module rs_lane_dispatcher #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned IN_BLOCK_LEN  = 255,
    parameter int unsigned OUT_BLOCK_LEN = 223,
    parameter int unsigned FIFO_DEPTH    = 512
) (
    input logic                 clk,
    input logic                 reset,
    rs_lane_dispatcher_if.slave bus
);
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned ICNT_W = (IN_BLOCK_LEN > 1) ? $clog2(IN_BLOCK_LEN) : 1;
    localparam int unsigned OCNT_W = (OUT_BLOCK_LEN > 1) ? $clog2(OUT_BLOCK_LEN) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [ICNT_W-1:0] IN_LAST   = ICNT_W'(IN_BLOCK_LEN - 1);
    localparam logic [OCNT_W-1:0] OUT_LAST  = OCNT_W'(OUT_BLOCK_LEN - 1);
    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  RESERVE   = CNT_W'(OUT_BLOCK_LEN);

    // Held low through reset so in_ready rises only after the first clock.
    logic                            alive_q;

    logic [LANE_W-1:0]               in_lane_q;
    logic [ICNT_W-1:0]               in_cnt_q;
    logic [LANE_W-1:0]               out_lane_q;
    logic [OCNT_W-1:0]               out_cnt_q;

    logic [CNT_W-1:0]                credit_q [NUM_LANES];
    logic [CNT_W-1:0]                credit_d [NUM_LANES];
    logic [CNT_W-1:0]                fill_q   [NUM_LANES];
    logic [CNT_W-1:0]                fill_d   [NUM_LANES];
    logic [PTR_W-1:0]                wr_ptr_q [NUM_LANES];
    logic [PTR_W-1:0]                rd_ptr_q [NUM_LANES];
    logic [DATA_WIDTH-1:0]           mem_q    [NUM_LANES][FIFO_DEPTH];

    logic [NUM_LANES-1:0]            lane_valid_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_q;
    logic [31:0]                     blocks_in_q;
    logic [31:0]                     blocks_out_q;
    logic                            overflow_q;

    logic                            in_ready;
    logic                            accept;
    logic                            in_last;
    logic                            out_valid;
    logic                            pop;
    logic                            out_last;
    logic [NUM_LANES-1:0]            dispatch_lane;
    logic [NUM_LANES-1:0]            reserve_lane;
    logic [NUM_LANES-1:0]            pop_lane;
    logic [NUM_LANES-1:0]            push;

    always_comb begin
        in_ready  = alive_q && !bus.flush &&
                    ((in_cnt_q != '0) || (credit_q[in_lane_q] >= RESERVE));
        accept    = bus.in_valid && in_ready;
        in_last   = (in_cnt_q == IN_LAST);
        out_valid = (fill_q[out_lane_q] != '0);
        pop       = out_valid && bus.out_ready;
        out_last  = (out_cnt_q == OUT_LAST);
    end

    // A full FIFO still takes a push when it is popped the same cycle.
    always_comb begin
        for (int l = 0; l < int'(NUM_LANES); l++) begin
            dispatch_lane[l] = accept && (in_lane_q == LANE_W'(l));
            reserve_lane[l]  = dispatch_lane[l] && (in_cnt_q == '0);
            pop_lane[l]      = pop && (out_lane_q == LANE_W'(l));
            push[l]          = bus.lane_valid_in[l] && ((fill_q[l] != DEPTH) || pop_lane[l]);
            credit_d[l]      = credit_q[l] + CNT_W'(pop_lane[l]) -
                               (reserve_lane[l] ? RESERVE : '0);
            fill_d[l]        = fill_q[l] + CNT_W'(push[l]) - CNT_W'(pop_lane[l]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive_q      <= 1'b0;
            in_lane_q    <= '0;
            in_cnt_q     <= '0;
            out_lane_q   <= '0;
            out_cnt_q    <= '0;
            lane_valid_q <= '0;
            lane_data_q  <= '0;
            blocks_in_q  <= '0;
            blocks_out_q <= '0;
            overflow_q   <= 1'b0;
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                credit_q[l] <= DEPTH;
                fill_q[l]   <= '0;
                wr_ptr_q[l] <= '0;
                rd_ptr_q[l] <= '0;
            end
        end else begin
            alive_q <= 1'b1;
            if (bus.flush) begin
                in_lane_q    <= '0;
                in_cnt_q     <= '0;
                out_lane_q   <= '0;
                out_cnt_q    <= '0;
                lane_valid_q <= '0;
                lane_data_q  <= '0;
                blocks_in_q  <= '0;
                blocks_out_q <= '0;
                overflow_q   <= 1'b0;
                for (int l = 0; l < int'(NUM_LANES); l++) begin
                    credit_q[l] <= DEPTH;
                    fill_q[l]   <= '0;
                    wr_ptr_q[l] <= '0;
                    rd_ptr_q[l] <= '0;
                end
            end else begin
                if (accept) begin
                    in_cnt_q <= in_last ? '0 : in_cnt_q + 1'b1;
                    if (in_last) begin
                        in_lane_q   <= (in_lane_q == LAST_LANE) ? '0 : in_lane_q + 1'b1;
                        blocks_in_q <= blocks_in_q + 32'd1;
                    end
                end

                if (pop) begin
                    out_cnt_q <= out_last ? '0 : out_cnt_q + 1'b1;
                    if (out_last) begin
                        out_lane_q   <= (out_lane_q == LAST_LANE) ? '0 : out_lane_q + 1'b1;
                        blocks_out_q <= blocks_out_q + 32'd1;
                    end
                end

                if (|(bus.lane_valid_in & ~push)) begin
                    overflow_q <= 1'b1;
                end

                lane_valid_q <= dispatch_lane;
                for (int l = 0; l < int'(NUM_LANES); l++) begin
                    if (dispatch_lane[l]) begin
                        lane_data_q[l*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
                    end
                    credit_q[l] <= credit_d[l];
                    fill_q[l]   <= fill_d[l];
                    if (push[l]) begin
                        wr_ptr_q[l] <= wr_ptr_q[l] + 1'b1;
                    end
                    if (pop_lane[l]) begin
                        rd_ptr_q[l] <= rd_ptr_q[l] + 1'b1;
                    end
                end
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int l = 0; l < int'(NUM_LANES); l++) begin
            if (push[l] && !bus.flush) begin
                mem_q[l][wr_ptr_q[l]] <= bus.lane_data_in[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid;
    assign bus.out_data       = out_valid ? mem_q[out_lane_q][rd_ptr_q[out_lane_q]] : '0;
    assign bus.lane_valid_out = lane_valid_q;
    assign bus.lane_data_out  = lane_data_q;
    assign bus.blocks_in      = blocks_in_q;
    assign bus.blocks_out     = blocks_out_q;
    assign bus.overflow_err   = overflow_q;

endmodule

// File: tb/tb_rs_lane_dispatcher.sv
// Bench for rs_lane_dispatcher: fixed-latency truncating lane models, an in-order
// truncated-block scoreboard, backpressure, flush and lane-overflow scenarios.
module tb_rs_lane_dispatcher;
    localparam int DW  = 8;
    localparam int NL  = 4;
    localparam int IBL = 255;
    localparam int OBL = 223;
    localparam int FD  = 512;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    initial forever #5 clk = ~clk;

    rs_lane_dispatcher_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

    rs_lane_dispatcher #(
        .DATA_WIDTH   (DW),
        .NUM_LANES    (NL),
        .IN_BLOCK_LEN (IBL),
        .OUT_BLOCK_LEN(OBL),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: expected output = first OBL symbols of each input block, in order.
    logic [DW-1:0]      exp_q[$];
    logic [DW:0]        dly [NL][64];
    int                 lat [NL];
    int                 lane_cnt [NL];
    int                 acc_cnt   = 0;
    int                 cyc       = 0;
    int                 pend      = 0;
    int                 inj_left  = 0;
    int                 rdy_mode  = 0;
    bit                 prev_acc  = 1'b0;
    int                 prev_lane = 0;
    logic [DW-1:0]      prev_data;
    bit                 prev_ov   = 1'b0;
    bit                 prev_pop  = 1'b0;
    bit                 prev_clr  = 1'b1;
    logic [NL-1:0]      lvi;
    logic [NL*DW-1:0]   ldi;
    int                 slot;

    // Environment/monitor: one process per negedge so model updates never race.
    initial begin
        bus.lane_valid_in = '0;
        bus.lane_data_in  = '0;
        forever begin
            @(negedge clk);
            if (reset || bus.flush) begin
                exp_q.delete();
                acc_cnt  = 0;
                pend     = 0;
                prev_acc = 1'b0;
                prev_ov  = 1'b0;
                prev_pop = 1'b0;
                prev_clr = 1'b1;
                for (int l = 0; l < NL; l++) begin
                    lane_cnt[l] = 0;
                    for (int s = 0; s < 64; s++) dly[l][s] = '0;
                end
                bus.lane_valid_in = '0;
            end else begin
                if (prev_acc || bus.lane_valid_out != '0) begin
                    check("lane_valid", 32'(bus.lane_valid_out), prev_acc ? (1 << prev_lane) : 0);
                    if (prev_acc)
                        check("lane_data", 32'(bus.lane_data_out[prev_lane*DW +: DW]),
                              32'(prev_data));
                end

                lvi  = '0;
                ldi  = '0;
                slot = cyc % 64;
                for (int l = 0; l < NL; l++) begin
                    if (dly[l][slot][DW]) begin
                        lvi[l]           = 1'b1;
                        ldi[l*DW +: DW]  = dly[l][slot][DW-1:0];
                        dly[l][slot]     = '0;
                        pend--;
                    end
                    if (bus.lane_valid_out[l]) begin
                        if (lane_cnt[l] < OBL) begin
                            dly[l][(cyc + lat[l]) % 64] = {1'b1, bus.lane_data_out[l*DW +: DW]};
                            pend++;
                        end
                        lane_cnt[l] = (lane_cnt[l] + 1) % IBL;
                    end
                end
                if (inj_left > 0) begin
                    lvi[2]          = 1'b1;
                    ldi[2*DW +: DW] = DW'($urandom);
                    inj_left--;
                end
                bus.lane_valid_in = lvi;
                bus.lane_data_in  = ldi;

                if (prev_ov && !prev_pop && !prev_clr)
                    check("out_valid_hold", 32'(bus.out_valid), 1);
                if (bus.out_valid && bus.out_ready) begin
                    check("out_pending", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0)
                        check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
                prev_ov  = bus.out_valid;
                prev_pop = bus.out_valid && bus.out_ready;
                prev_clr = 1'b0;

                prev_acc = bus.in_valid && bus.in_ready;
                if (prev_acc) begin
                    prev_lane = (acc_cnt / IBL) % NL;
                    prev_data = bus.in_data;
                    if ((acc_cnt % IBL) < OBL) exp_q.push_back(bus.in_data);
                    acc_cnt++;
                end
            end
            cyc++;
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_syms(input int n, input int pct, input bit rnd, input int max_cyc,
                             output int sent);
        int i = 0;
        sent = 0;
        while (sent < n && i < max_cyc) begin
            @(posedge clk);
            #1;
            bus.in_valid = ($urandom_range(1, 100) <= pct);
            bus.in_data  = rnd ? DW'($urandom) : DW'(sent % IBL);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
            i++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int i = 0;
        while ((exp_q.size() != 0 || pend != 0) && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        check("idle_reached", 32'(exp_q.size() + pend), 0);
    endtask

    task automatic wait_inj();
        int i = 0;
        while (inj_left != 0 && i < 1000) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        check("inj_done", 32'(inj_left), 0);
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int sent;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int l = 0; l < NL; l++) lat[l] = 10;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",   32'(bus.in_ready), 0);
        check("rst_out_valid",  32'(bus.out_valid), 0);
        check("rst_out_data",   32'(bus.out_data), 0);
        check("rst_lane_valid", 32'(bus.lane_valid_out), 0);
        check("rst_lane_data",  bus.lane_data_out, 0);
        check("rst_blocks_in",  bus.blocks_in, 0);
        check("rst_blocks_out", bus.blocks_out, 0);
        check("rst_overflow",   32'(bus.overflow_err), 0);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 32'(bus.in_ready), 1);

        // 8 blocks, uniform latency, consumer always ready
        rdy_mode = 1;
        send_syms(8 * IBL, 100, 1'b0, 8 * IBL + 100, sent);
        check("t1_sent", sent, 8 * IBL);
        wait_idle(3000);
        check("t1_blocks_in",  bus.blocks_in, 8);
        check("t1_blocks_out", bus.blocks_out, 8);

        // Skewed lane latencies must not reorder output
        lat[0] = 40; lat[1] = 5; lat[2] = 25; lat[3] = 1;
        send_syms(8 * IBL, 100, 1'b0, 8 * IBL + 100, sent);
        check("t2_sent", sent, 8 * IBL);
        wait_idle(3000);
        check("t2_blocks_in",  bus.blocks_in, 16);
        check("t2_blocks_out", bus.blocks_out, 16);

        // Random valid/ready
        for (int l = 0; l < NL; l++) lat[l] = 10;
        rdy_mode = 2;
        send_syms(40 * IBL, 70, 1'b1, 40 * IBL * 4, sent);
        check("t4_sent", sent, 40 * IBL);
        wait_idle(30000);
        check("t4_blocks_in",  bus.blocks_in, 56);
        check("t4_blocks_out", bus.blocks_out, 56);

        // Stalled consumer: credits allow exactly 2 blocks per lane
        rdy_mode = 0;
        send_syms(10 * IBL, 100, 1'b1, 8 * IBL + 200, sent);
        check("bp_sent",      sent, 8 * IBL);
        check("bp_in_ready",  32'(bus.in_ready), 0);
        check("bp_blocks_in", bus.blocks_in, 64);
        rdy_mode = 1;
        send_syms(2 * IBL, 100, 1'b1, 4000, sent);
        check("bp_resume_sent", sent, 2 * IBL);
        wait_idle(4000);
        check("bp_blocks_in_end",  bus.blocks_in, 66);
        check("bp_blocks_out_end", bus.blocks_out, 66);

        // Flush mid-block
        rdy_mode = 0;
        send_syms(100, 100, 1'b1, 200, sent);
        check("fl_sent", sent, 100);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("fl_in_ready_low", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("fl_in_ready",   32'(bus.in_ready), 1);
        check("fl_blocks_in",  bus.blocks_in, 0);
        check("fl_blocks_out", bus.blocks_out, 0);
        check("fl_out_valid",  32'(bus.out_valid), 0);
        check("fl_lane_valid", 32'(bus.lane_valid_out), 0);
        send_syms(1, 100, 1'b1, 10, sent);
        @(negedge clk);
        check("fl_new_block_lane0", 32'(bus.lane_valid_out), 1);
        repeat (20) @(negedge clk);
        pulse_flush();
        check("fl2_out_valid", 32'(bus.out_valid), 0);

        // Faulty lane 2 overruns its FIFO
        inj_left = FD;
        wait_inj();
        check("ovf_at_full", 32'(bus.overflow_err), 0);
        inj_left = 1;
        wait_inj();
        check("ovf_after_extra", 32'(bus.overflow_err), 1);
        inj_left = 600 - FD - 1;
        wait_inj();
        check("ovf_sticky",     32'(bus.overflow_err), 1);
        check("ovf_out_valid",  32'(bus.out_valid), 0);
        pulse_flush();
        check("ovf_cleared",    32'(bus.overflow_err), 0);
        check("ovf_in_ready",   32'(bus.in_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
